mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl.sv | 84 ++++++++
 tb/tb_mult_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// mult_ctrl: add/shift sequencer for a WIDTH-bit signed multiplier datapath.
// Optional macro MULT_CTRL_RUN_SYNC_EN inserts a 2-flop synchronizer on Run.
module mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clr_XA,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          run;

`ifdef MULT_CTRL_RUN_SYNC_EN
  logic run_meta;
  logic run_sync;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_meta <= Run;
      run_sync <= run_meta;
    end
  end

  assign run = run_sync;
`else
  assign run = Run;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (run) state <= CLEAR;
        CLEAR: begin
          state <= ADD;
          cnt   <= '0;
        end
        ADD:   state <= SHIFT;
        SHIFT: begin
          if (cnt != LAST) begin
            state <= ADD;
            cnt   <= cnt + 1'b1;
          end else begin
            state <= DONE;
          end
        end
        // Holding here until Run drops keeps a level Run to one multiply.
        DONE:    if (!run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clr_Ld is gated by Reset_n so it stays low while reset is asserted.
  assign Clr_Ld = Reset_n && (state == IDLE) && ClearA_LoadB;
  assign Clr_XA = (state == CLEAR);
  assign Add    = (state == ADD) && M && (cnt != LAST);
  assign Sub    = (state == ADD) && M && (cnt == LAST);
  assign Shift  = (state == SHIFT);
  assign Busy   = (state == CLEAR) || (state == ADD) || (state == SHIFT);
  assign Done   = (state == DONE);

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed and randomized checks of mult_ctrl against a
// cycle-schedule model (position within a multiply), WIDTH=8.
module tb_mult_ctrl;

  localparam int unsigned W = 8;
  localparam int NW = W;
`ifdef MULT_CTRL_RUN_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int DONEPOS = 2 * NW + 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M = 1'b0;
  logic Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int n_clrxa = 0, n_add = 0, n_sub = 0, n_shift = 0, n_done = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub), .Shift(Shift),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Model: pos = -1 when idle, otherwise cycles elapsed since the multiply began.
  int pos = -1;
  logic [1:0] hist = '0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos  = -1;
      hist = '0;
    end else begin
      logic run_eff;
      run_eff = (SYNC == 0) ? Run : hist[1];
      hist = {hist[0], Run};
      if (pos < 0) pos = run_eff ? 0 : -1;
      else if (pos < DONEPOS) pos = pos + 1;
      else if (!run_eff) pos = -1;
    end
  end

  // {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}
  function automatic logic [6:0] expect_out(int p, logic m, logic cl, logic rn);
    logic add_cyc, shf, last;
    add_cyc = (p >= 1) && (p <= 2 * NW) && (p % 2 == 1);
    shf     = (p >= 2) && (p <= 2 * NW) && (p % 2 == 0);
    last    = ((p - 1) / 2) == (NW - 1);
    return {rn && cl && (p < 0), p == 0, add_cyc && m && !last, add_cyc && m && last,
            shf, (p >= 0) && (p <= 2 * NW), p == DONEPOS};
  endfunction

  task automatic check_outputs(string tag);
    logic [6:0] act, exp;
    act = {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done};
    exp = expect_out(pos, M, ClearA_LoadB, Reset_n);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s outputs{ClrLd,ClrXA,Add,Sub,Shift,Busy,Done} actual=%b required=%b pos=%0d t=%0t",
               tag, act, exp, pos, $time);
    end
  endtask

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) check_outputs("cycle");
    n_clrxa += int'(Clr_XA);
    n_add   += int'(Add);
    n_sub   += int'(Sub);
    n_shift += int'(Shift);
    n_done  += int'(Done);
  end

  task automatic clear_counts();
    n_clrxa = 0; n_add = 0; n_sub = 0; n_shift = 0; n_done = 0;
  endtask

  task automatic wait_idle(string name);
    int k;
    k = 0;
    while ((Busy || Done) && k < 100) begin
      @(posedge Clk); #1;
      k++;
    end
    check(name, int'(Busy || Done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge Clk);
    check("reset_idle_busy", int'(Busy), 0);
    check("reset_idle_done", int'(Done), 0);

    // Single-cycle Run pulse, M=1: 7 Add, 1 Sub, 8 Shift, Done after edge 18.
    @(posedge Clk); #1;
    M = 1'b1; Run = 1'b1;
    clear_counts();
    @(posedge Clk); #1 Run = 1'b0;
    k = 1;
    while (k < 100) begin
      @(negedge Clk);
      if (Done) break;
      @(posedge Clk);
      k++;
    end
    check("done_latency", k, 18 + SYNC);
    @(posedge Clk); #1;
    wait_idle("pulse_returns_idle");
    repeat (2) @(posedge Clk); #1;
    check("pulse_clrxa_count", n_clrxa, 1);
    check("pulse_add_count", n_add, 7);
    check("pulse_sub_count", n_sub, 1);
    check("pulse_shift_count", n_shift, 8);
    check("pulse_done_count", n_done, 1);

    // Run held 40 edges with M=0: one multiply only, Done for 23 cycles.
    M = 1'b0; Run = 1'b1;
    clear_counts();
    repeat (40) @(posedge Clk);
    #1 Run = 1'b0;
    repeat (10) @(posedge Clk); #1;
    check("held_clrxa_count", n_clrxa, 1);
    check("held_add_count", n_add, 0);
    check("held_sub_count", n_sub, 0);
    check("held_shift_count", n_shift, 8);
    check("held_done_count", n_done, 23);
    check("held_back_idle", int'(Busy || Done), 0);

    // ClearA_LoadB honoured in IDLE, ignored during SHIFT.
    ClearA_LoadB = 1'b1;
    #1 check("clrld_idle", int'(Clr_Ld), 1);
    @(posedge Clk); #1 ClearA_LoadB = 1'b0;
    Run = 1'b1;
    @(posedge Clk); #1 Run = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge Clk);
      if (Shift) break;
      k++;
    end
    check("shift_reached", int'(Shift), 1);
    #1 ClearA_LoadB = 1'b1;
    #1 check("clrld_in_shift", int'(Clr_Ld), 0);
    @(posedge Clk); #1 ClearA_LoadB = 1'b0;
    repeat (25) @(posedge Clk); #1;
    wait_idle("clrld_mult_completes");

    // Asynchronous reset mid-multiply, then no activity until a new Run.
    M = 1'b1; Run = 1'b1;
    @(posedge Clk); #1 Run = 1'b0;
    repeat (6 + SYNC) @(posedge Clk);
    @(negedge Clk);
    check("pre_reset_busy", int'(Busy), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}), 0);
    check_outputs("async_reset_model");
    @(posedge Clk); #1 Reset_n = 1'b1;
    clear_counts();
    repeat (20) @(posedge Clk); #1;
    check("post_reset_shift_count", n_shift, 0);
    check("post_reset_add_count", n_add + n_sub, 0);
    check("post_reset_busy", int'(Busy), 0);

    // Run already high at reset release starts on the first edge (plus sync delay).
    Reset_n = 1'b0;
    Run = 1'b1;
    @(posedge Clk); #1 Reset_n = 1'b1;
    repeat (1 + SYNC) @(posedge Clk);
    @(negedge Clk);
    check("release_start_clrxa", int'(Clr_XA), 1);
    #1 Run = 1'b0;
    repeat (25) @(posedge Clk); #1;
    wait_idle("release_mult_completes");

    // Randomized traffic; every cycle checked against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clk); #1;
      if ($urandom_range(0, 7) == 0) Run = ~Run;
      M = 1'($urandom_range(0, 1));
      ClearA_LoadB = ($urandom_range(0, 3) == 0);
      if (!Reset_n) Reset_n = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 399) == 0) Reset_n = 1'b0;
    end
    @(posedge Clk); #1 Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
